// File: rtl/icache_tag_port_arbiter.sv
// ICache tag-port arbiter: shares the single tag-array port between Fetch1
// reads, refill tag writes and a full-cache invalidate walker, and drives the
// ITag/ITLB avail qualifiers seen by Fetch1. Refill is throttled so a
// continuously requesting refill unit cannot lock fetch out of the port.
module icache_tag_port_arbiter #(
  parameter  int NUM_SETS   = 64,
  parameter  int MAX_STARVE = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_SETS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fetch_want,
  input  logic                 i_refill_req,
  input  logic [IDX_WIDTH-1:0] i_refill_idx,
  input  logic                 i_inv_start,
  output logic                 o_icache_tag_avail,
  output logic                 o_itlb_avail,
  output logic                 o_refill_grant,
  output logic                 o_tag_we,
  output logic                 o_tag_clear,
  output logic [IDX_WIDTH-1:0] o_tag_idx,
  output logic                 o_itlb_flush,
  output logic                 o_inv_busy,
  output logic                 o_inv_done
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SETS - 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic {IDLE, WALK} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] walk_idx_q, walk_idx_d;
  logic                 inv_pend_q, inv_pend_d;
  logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
  logic                 inv_done_q, inv_done_d;

  logic in_idle;
  logic in_walk;
  logic block;
  logic grant;
  logic fetch_avail;

  // Arbitration terms; the grant is masked during reset so the outputs sit
  // at their reset values even while a refill request is held.
  always_comb begin
    in_idle     = (state_q == IDLE);
    in_walk     = (state_q == WALK);
    block       = (starve_cnt_q == STARVE_MAX);
    grant       = in_idle & i_refill_req & ~block & ~i_rst;
    fetch_avail = in_idle & ~grant;
  end

  // State and walker registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      walk_idx_q   <= '0;
      inv_pend_q   <= 1'b0;
      starve_cnt_q <= '0;
      inv_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_idx_q   <= walk_idx_d;
      inv_pend_q   <= inv_pend_d;
      starve_cnt_q <= starve_cnt_d;
      inv_done_q   <= inv_done_d;
    end
  end

  // Next-state: start a walk from IDLE on a fresh or pending invalidate; a
  // walk runs once over every set and a start seen mid-walk is remembered.
  always_comb begin
    state_d    = state_q;
    walk_idx_d = walk_idx_q;
    inv_pend_d = inv_pend_q;
    inv_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_inv_start | inv_pend_q) begin
          state_d    = WALK;
          inv_pend_d = 1'b0;
          walk_idx_d = '0;
        end
      end
      WALK: begin
        walk_idx_d = walk_idx_q + 1'b1;
        if (i_inv_start) inv_pend_d = 1'b1;
        if (walk_idx_q == LAST_IDX) begin
          state_d    = IDLE;
          inv_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: counts consecutive cycles fetch wanted the port but
  // lost it to refill; frozen while the walker owns the port.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_fetch_want || fetch_avail)
      starve_cnt_d = '0;
    else if (grant && starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Outputs: the walker and the refill grant are mutually exclusive by state,
  // so the write port is never driven by two sources.
  always_comb begin
    o_icache_tag_avail = fetch_avail;
    o_itlb_avail       = in_idle;
    o_refill_grant     = grant;
    o_tag_we           = grant | in_walk;
    o_tag_clear        = in_walk;
    o_tag_idx          = '0;
    if (in_walk)    o_tag_idx = walk_idx_q;
    else if (grant) o_tag_idx = i_refill_idx;
    o_itlb_flush       = in_walk & (walk_idx_q == '0);
    o_inv_busy         = in_walk | inv_pend_q;
    o_inv_done         = inv_done_q;
  end

endmodule

// File: tb/tb_icache_tag_port_arbiter.sv
// Directed bench for icache_tag_port_arbiter (NUM_SETS=64, MAX_STARVE=4).
// Stimulus pushes the hand-derived expected outputs for each driven cycle;
// a monitor on the falling edge pops and compares.
module tb_icache_tag_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       want = 1'b0, req = 1'b0, inv = 1'b0;
  logic [5:0] ridx = '0;

  logic       avail, itlb, gnt, we, clr, flush, busy, done;
  logic [5:0] tidx;

  typedef struct packed {
    logic       av;
    logic       ita;
    logic       gnt;
    logic       we;
    logic       clr;
    logic [5:0] idx;
    logic       fl;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  icache_tag_port_arbiter #(.NUM_SETS(64), .MAX_STARVE(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_fetch_want       (want),
    .i_refill_req       (req),
    .i_refill_idx       (ridx),
    .i_inv_start        (inv),
    .o_icache_tag_avail (avail),
    .o_itlb_avail       (itlb),
    .o_refill_grant     (gnt),
    .o_tag_we           (we),
    .o_tag_clear        (clr),
    .o_tag_idx          (tidx),
    .o_itlb_flush       (flush),
    .o_inv_busy         (busy),
    .o_inv_done         (done)
  );

  function automatic exp_t mk(logic av, logic ita, logic g, logic w, logic c,
                              logic [5:0] ix, logic f, logic b, logic d);
    exp_t e;
    e.av = av; e.ita = ita; e.gnt = g; e.we = w; e.clr = c;
    e.idx = ix; e.fl = f; e.busy = b; e.done = d;
    return e;
  endfunction

  // Common expectation shapes.
  function automatic exp_t e_idle(logic d);
    return mk(1, 1, 0, 0, 0, 6'd0, 0, 0, d);
  endfunction
  function automatic exp_t e_grant(logic [5:0] ix, logic b, logic d);
    return mk(0, 1, 1, 1, 0, ix, 0, b, d);
  endfunction
  function automatic exp_t e_walk(int i);
    return mk(0, 0, 0, 1, 1, 6'(i), (i == 0), 1, 0);
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic step(input logic r, input logic w, input logic rq,
                      input logic [5:0] ix, input logic iv, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; want = w; req = rq; ridx = ix; inv = iv;
    q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = mk(avail, itlb, gnt, we, clr, tidx, flush, busy, done);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc@%0t outputs: got av=%b ita=%b gnt=%b we=%b clr=%b idx=%0d fl=%b busy=%b done=%b, want av=%b ita=%b gnt=%b we=%b clr=%b idx=%0d fl=%b busy=%b done=%b",
                 $time, a.av, a.ita, a.gnt, a.we, a.clr, a.idx, a.fl, a.busy, a.done,
                 e.av, e.ita, e.gnt, e.we, e.clr, e.idx, e.fl, e.busy, e.done);
      end
    end
  end

  initial begin
    // Reset held with a refill request pending: only the avails are high.
    step(1, 1, 1, 6'd2, 0, e_idle(0));
    step(1, 1, 1, 6'd2, 0, e_idle(0));

    // 1. Out of reset, fetch wanting, nothing else.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'd0, 0, e_idle(0));

    // 2. Single refill, fetch idle.
    step(0, 0, 1, 6'd5, 0, e_grant(6'd5, 0, 0));
    step(0, 0, 0, 6'd0, 0, e_idle(0));

    // 3. Continuous refill against a wanting fetch: 4 grants then 1 block.
    for (int k = 0; k < 10; k++)
      step(0, 1, 1, 6'd9, 0, (k % 5 == 4) ? e_idle(0) : e_grant(6'd9, 0, 0));
    step(0, 1, 0, 6'd0, 0, e_idle(0));

    // 4. One full invalidate walk.
    step(0, 1, 0, 6'd0, 1, e_idle(0));
    for (int i = 0; i < 64; i++) step(0, 1, 0, 6'd0, 0, e_walk(i));
    step(0, 1, 0, 6'd0, 0, e_idle(1));
    step(0, 1, 0, 6'd0, 0, e_idle(0));

    // 5. Restart requested mid-walk, refill held across both walks.
    step(0, 0, 0, 6'd0, 1, e_idle(0));
    for (int i = 0; i < 64; i++) step(0, 0, 1, 6'd7, (i == 20), e_walk(i));
    step(0, 0, 1, 6'd7, 0, e_grant(6'd7, 1, 1));
    for (int i = 0; i < 64; i++) step(0, 0, 1, 6'd7, 0, e_walk(i));
    step(0, 0, 1, 6'd7, 0, e_grant(6'd7, 0, 1));
    step(0, 0, 0, 6'd0, 0, e_idle(0));

    // 6. Reset in the middle of a walk aborts it without a done pulse.
    step(0, 1, 0, 6'd0, 1, e_idle(0));
    for (int i = 0; i < 30; i++) step(0, 1, 0, 6'd0, 0, e_walk(i));
    step(1, 1, 1, 6'd4, 0, e_idle(0));
    step(1, 1, 1, 6'd4, 0, e_idle(0));
    step(0, 1, 0, 6'd0, 0, e_idle(0));
    step(0, 1, 0, 6'd0, 0, e_idle(0));
    step(0, 1, 1, 6'd3, 0, e_grant(6'd3, 0, 0));
    step(0, 1, 0, 6'd0, 0, e_idle(0));

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
